// File: rtl/mixed_width_sync_fifo_if.sv
// Handshake and status bundle for the mixed-width FIFO.
// The user side drives data and requests; the FIFO drives q, flags and counts.
interface mixed_width_sync_fifo_if #(
    parameter int WIDTH_W  = 64,
    parameter int WIDTHU_W = 10,
    parameter int WIDTH_R  = 128,
    parameter int WIDTHU_R = 9
);
    logic [WIDTH_W-1:0]  data;
    logic                wrreq;
    logic                rdreq;
    logic [WIDTH_R-1:0]  q;
    logic                wrfull;
    logic                rdfull;
    logic                wrempty;
    logic                rdempty;
    logic [WIDTHU_W-1:0] wrusedw;
    logic [WIDTHU_R-1:0] rdusedw;
    logic [1:0]          eccstatus;

    modport master (
        output data, wrreq, rdreq,
        input  q, wrfull, rdfull, wrempty, rdempty, wrusedw, rdusedw, eccstatus
    );

    modport slave (
        input  data, wrreq, rdreq,
        output q, wrfull, rdfull, wrempty, rdempty, wrusedw, rdusedw, eccstatus
    );
endinterface

// File: rtl/mixed_width_sync_fifo.sv
// Single-clock FIFO: narrow write words in, pairs of them out as one wide read word.
// Older word of each pair lands in the low half of q.
module mixed_width_sync_fifo #(
    parameter int WIDTH_W  = 64,
    parameter int DEPTH_W  = 1024,
    parameter int WIDTHU_W = 10,
    parameter int WIDTH_R  = 128,
    parameter int WIDTHU_R = 9
) (
    input  logic                   clk,
    input  logic                   arst_n,
    mixed_width_sync_fifo_if.slave bus
);
    localparam int HALF = DEPTH_W / 2;
    localparam int CW   = WIDTHU_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH_W);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    // Storage split into even/odd banks so one read port fetches a whole pair.
    logic [WIDTH_W-1:0]  mem_lo [HALF];
    logic [WIDTH_W-1:0]  mem_hi [HALF];

    logic [WIDTHU_W-1:0] wr_ptr;
    logic [WIDTHU_R-1:0] rd_ptr;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nx;
    logic [WIDTH_R-1:0]  q_r;
    logic                full;
    logic                rd_empty;
    logic                wr_acc;
    logic                rd_acc;

    assign full     = (cnt == FULL_CNT);
    assign rd_empty = (cnt < TWO);
    assign wr_acc   = bus.wrreq && !full;
    assign rd_acc   = bus.rdreq && !rd_empty;

    always_ff @(posedge clk) begin
        if (arst_n && wr_acc) begin
            if (wr_ptr[0])
                mem_hi[wr_ptr[WIDTHU_W-1:1]] <= bus.data;
            else
                mem_lo[wr_ptr[WIDTHU_W-1:1]] <= bus.data;
        end
    end

    always_comb begin
        cnt_nx = cnt;
        if (wr_acc)
            cnt_nx = cnt_nx + ONE;
        if (rd_acc)
            cnt_nx = cnt_nx - TWO;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            q_r    <= '0;
        end else begin
            cnt <= cnt_nx;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                q_r    <= {mem_hi[rd_ptr], mem_lo[rd_ptr]};
            end
        end
    end

    // Counts wrap to zero at full; the flags disambiguate.
    assign bus.q         = q_r;
    assign bus.wrfull    = full;
    assign bus.rdfull    = (cnt >= FULL_CNT);
    assign bus.wrempty   = (cnt == '0);
    assign bus.rdempty   = rd_empty;
    assign bus.wrusedw   = cnt[WIDTHU_W-1:0];
    assign bus.rdusedw   = cnt[WIDTHU_R:1];
    assign bus.eccstatus = 2'b00;
endmodule

// File: tb/tb_mixed_width_sync_fifo.sv
// Directed bench for mixed_width_sync_fifo with a word-queue reference model.
module tb_mixed_width_sync_fifo;
    logic clk;
    logic arst_n;

    mixed_width_sync_fifo_if bus_if ();

    mixed_width_sync_fifo dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    logic [63:0]   m_words [$];
    logic [127:0]  exp_rd  [$];
    logic [10:0]   m_cnt;
    logic [127:0]  m_q;
    logic          last_wacc;
    logic [63:0]   next_d;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q"},       bus_if.q, m_q);
        chk({tag, "_wrfull"},  128'(bus_if.wrfull),  128'(m_cnt == 11'd1024));
        chk({tag, "_rdfull"},  128'(bus_if.rdfull),  128'(m_cnt >= 11'd1024));
        chk({tag, "_wrempty"}, 128'(bus_if.wrempty), 128'(m_cnt == 11'd0));
        chk({tag, "_rdempty"}, 128'(bus_if.rdempty), 128'(m_cnt < 11'd2));
        chk({tag, "_wrusedw"}, 128'(bus_if.wrusedw), 128'(m_cnt % 1024));
        chk({tag, "_rdusedw"}, 128'(bus_if.rdusedw), 128'((m_cnt / 2) % 512));
        chk({tag, "_ecc"},     128'(bus_if.eccstatus), 128'(0));
    endtask

    // One clock of stimulus; acceptance judged from the model count before the edge.
    task automatic step(input logic wr, input logic rd, input logic [63:0] d);
        logic        wacc;
        logic        racc;
        logic [63:0] w0;
        logic [63:0] w1;
        wacc = wr && (m_cnt != 11'd1024);
        racc = rd && (m_cnt >= 11'd2);
        bus_if.wrreq = wr;
        bus_if.rdreq = rd;
        bus_if.data  = d;
        if (racc) begin
            w0 = m_words.pop_front();
            w1 = m_words.pop_front();
            exp_rd.push_back({w1, w0});
        end
        if (wacc)
            m_words.push_back(d);
        m_cnt = m_cnt + 11'(wacc) - (racc ? 11'd2 : 11'd0);
        @(posedge clk);
        #1;
        if (racc)
            m_q = exp_rd.pop_front();
        check_all("step");
        last_wacc = wacc;
    endtask

    task automatic model_clear();
        m_words.delete();
        exp_rd.delete();
        m_cnt = '0;
        m_q   = '0;
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic mid_reset(input string tag);
        #2;
        arst_n = 1'b0;
        #1;
        model_clear();
        check_all(tag);
        repeat (2) @(posedge clk);
        #1;
        check_all({tag, "_hold"});
        @(negedge clk);
        arst_n       = 1'b1;
        bus_if.wrreq = 1'b0;
        bus_if.rdreq = 1'b0;
    endtask

    initial begin
        clk          = 1'b0;
        arst_n       = 1'b0;
        bus_if.data  = '0;
        bus_if.wrreq = 1'b0;
        bus_if.rdreq = 1'b0;
        last_wacc    = 1'b0;
        model_clear();

        repeat (10) @(posedge clk);
        #1;
        check_all("rst");
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check_all("rst_rel");

        // Fill past capacity; data advances only on accepted writes.
        next_d = '0;
        for (int i = 0; i < 1030; i++) begin
            step(1'b1, 1'b0, next_d);
            if (last_wacc)
                next_d++;
        end
        chk("fill_wrfull",  128'(bus_if.wrfull),  128'(1));
        chk("fill_rdfull",  128'(bus_if.rdfull),  128'(1));
        chk("fill_wrusedw", 128'(bus_if.wrusedw), 128'(0));
        chk("fill_wrempty", 128'(bus_if.wrempty), 128'(0));
        chk("fill_count",   128'(next_d),         128'(1024));

        // Drain, including one read past empty.
        step(1'b0, 1'b1, 64'd0);
        chk("drain_first", bus_if.q, {64'd1, 64'd0});
        for (int i = 1; i < 512; i++)
            step(1'b0, 1'b1, 64'd0);
        chk("drain_last", bus_if.q, {64'd1023, 64'd1022});
        step(1'b0, 1'b1, 64'd0);
        chk("drain_under", bus_if.q, {64'd1023, 64'd1022});
        chk("drain_rdempty", 128'(bus_if.rdempty), 128'(1));

        // Concurrent streaming from empty.
        mid_reset("rst_stream");
        next_d = 64'h5000;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, next_d);
            next_d++;
        end
        chk("stream_last", bus_if.q, {64'h5000 + 64'd37, 64'h5000 + 64'd36});

        // Odd leftover word stays unreadable until its partner arrives.
        mid_reset("rst_odd");
        step(1'b1, 1'b0, 64'hA);
        step(1'b1, 1'b0, 64'hB);
        step(1'b1, 1'b0, 64'hC);
        step(1'b0, 1'b1, 64'd0);
        chk("odd_first", bus_if.q, {64'hB, 64'hA});
        chk("odd_rdempty", 128'(bus_if.rdempty), 128'(1));
        step(1'b0, 1'b1, 64'd0);
        chk("odd_ignored", bus_if.q, {64'hB, 64'hA});
        step(1'b1, 1'b0, 64'hD);
        chk("odd_ready", 128'(bus_if.rdempty), 128'(0));
        step(1'b0, 1'b1, 64'd0);
        chk("odd_second", bus_if.q, {64'hD, 64'hC});

        // Async reset with 500 words held and a write pending across reset.
        for (int i = 0; i < 500; i++)
            step(1'b1, 1'b0, 64'h9000 + 64'(i));
        chk("mid_wrusedw", 128'(bus_if.wrusedw), 128'(500));
        bus_if.wrreq = 1'b1;
        mid_reset("rst_mid");
        step(1'b1, 1'b0, 64'h77);
        step(1'b1, 1'b0, 64'h88);
        step(1'b0, 1'b1, 64'd0);
        chk("mid_first", bus_if.q, {64'h88, 64'h77});
        step(1'b0, 1'b0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mixed_width_sync_fifo.md
Name: mixed_width_sync_fifo

Overview:
- Single-clock FIFO with a narrow write port and a wide read port. Default: 64-bit write, 128-bit read, 1024 write-word depth.
- Each read word is packed from two consecutive write words.
- Used as the storage core under the compat FIFO wrappers. The wrapper derives prog_full from wrusedw and swaps read halves as needed.

Parameters:
- WIDTH_W, 64, write data width.
- DEPTH_W, 1024, capacity in write words (power of two).
- WIDTHU_W, 10, log2(DEPTH_W); width of wrusedw.
- WIDTH_R, 128, read data width; must equal 2*WIDTH_W.
- WIDTHU_R, 9, log2(DEPTH_W/2); width of rdusedw.

Ports:
- clk  in  1  single clock for both ports.
- arst_n  in  1  asynchronous active-low reset; clears all state.
- data  in  WIDTH_W  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request.
- q  out  WIDTH_R  registered read data.
- wrfull  out  1  FIFO holds DEPTH_W write words.
- rdfull  out  1  FIFO holds DEPTH_W/2 complete read words.
- wrempty  out  1  FIFO holds 0 write words.
- rdempty  out  1  fewer than 2 write words held (no complete read word).
- wrusedw  out  WIDTHU_W  write words held, modulo DEPTH_W.
- rdusedw  out  WIDTHU_R  complete read words held (cnt/2), modulo DEPTH_W/2.
- eccstatus  out  2  tied to 2'b00.

Behaviour:
- State:
  - Write pointer (write-word granularity).
  - Read pointer (read-word granularity).
  - Occupancy counter cnt in write words, range 0..DEPTH_W; needs WIDTHU_W+1 bits internally.
  - Storage: DEPTH_W x WIDTH_W RAM, or an equivalent organisation.
- Reset (arst_n low, asynchronous):
  - Pointers and cnt go to 0; q goes to 0.
  - Outputs then read: wrempty=1, rdempty=1, wrfull=0, rdfull=0, wrusedw=0, rdusedw=0.
  - Reset mid-operation discards all contents immediately. No operation takes effect on the edge where arst_n is low.
- Write:
  - On posedge clk with wrreq=1 and wrfull=0, data is stored at the write pointer and the pointer advances by 1, wrapping DEPTH_W-1 -> 0.
  - wrreq while wrfull=1 is ignored (overflow protection); contents unchanged.
- Read (non-showahead):
  - On posedge clk with rdreq=1 and rdempty=0, q loads the oldest two write words and the read pointer advances by 1 (wraps).
  - Packing: older word in q[WIDTH_W-1:0], newer word in q[WIDTH_R-1:WIDTH_W].
  - Latency is one clock from the rdreq edge to valid q.
  - q holds its value when no read occurs.
  - rdreq while rdempty=1 is ignored (underflow protection); q unchanged.
- Occupancy:
  - cnt_next = cnt + (accepted write ? 1 : 0) - (accepted read ? 2 : 0).
  - A simultaneous accepted read and write is legal and nets -1.
  - Acceptance is decided from flags before the edge. A write at cnt=DEPTH_W is rejected even if a read occurs on the same edge; a read at cnt<2 is rejected even if a write occurs on the same edge.
- Flags and counts are combinational from the registered cnt, so they update in the cycle after the accepting edge:
  - wrfull = (cnt == DEPTH_W).
  - rdfull = (cnt >= DEPTH_W), i.e. DEPTH_W/2 read words.
  - wrempty = (cnt == 0).
  - rdempty = (cnt < 2).
  - wrusedw = cnt[WIDTHU_W-1:0], which reads 0 when full. Consumers distinguish full from empty with the flags.
  - rdusedw = cnt[WIDTHU_W:1] truncated to WIDTHU_R bits, which reads 0 when full.
- Odd occupancy: a single leftover write word stays unreadable (rdempty=1) until its partner is written.

Test Plan:
- Reset check: hold arst_n=0 for 10 cycles, then release.
  -> q=0, wrempty=1, rdempty=1, wrfull=0, wrusedw=0, rdusedw=0.
- Fill: wrreq=1 continuously with data = 0,1,2,… (data advances only while wrfull=0), rdreq=0.
  -> wrusedw counts 1..1023.
  -> wrfull=1 and rdfull=1 after 1024 accepted writes; wrusedw then reads 0 with wrempty=0.
  -> Further writes are ignored.
- Drain after fill: rdreq=1 continuously.
  -> First q (one cycle after the first rdreq edge) = {64'd1, 64'd0}; next {64'd3, 64'd2}, and so on up to {64'd1023, 64'd1022}.
  -> rdempty=1 after 512 reads; a further rdreq leaves q unchanged.
- Concurrent streaming: wrreq=1 and rdreq=1 from reset with incrementing data.
  -> Reads are accepted only when cnt>=2.
  -> Output stays in order with no gaps or duplicates; cnt stays bounded (0..2).
- Odd leftover: write 3 words (A,B,C), then read twice.
  -> First read gives {B,A}; rdempty=1 afterwards; second rdreq is ignored.
  -> Writing D makes rdempty=0; the next read gives {D,C}.
- Async reset mid-stream: assert arst_n=0 between clock edges with 500 words held.
  -> Counts, flags and q go to reset values immediately, before the next edge.
  -> After release, the first data written is the first data read.
